regfile_scoreboard: RTL and testbench

- Parametrised integer register file for the pipelined core: 2 asynchronous read ports, 1 synchronous write port.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Integrated per-register busy scoreboard: set when ID allocates a destination, cleared on WB write. Lets the hazard unit stall on RAW dependencies without scanning pipeline registers.

---
 rtl/regfile_scoreboard.sv | 130 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with two async read ports, one sync write port,
// optional hardwired zero register, optional write bypass and a busy scoreboard.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rs1_addr, rs2_addr    read addresses
//   rs1_data, rs2_data    combinational read data
//   rs1_busy, rs2_busy    outstanding-write flag for each read register
//   we, wr_addr, wr_data  WB write port; a write also clears the busy bit
//   alloc_valid, alloc_rd ID destination allocation; sets the busy bit
//   flush                 drops every outstanding allocation
//   pending_cnt           number of busy registers (registered)
//   full_zero_hit         allocation aimed at the hardwired zero register
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREG),
    localparam int unsigned CW      = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            alloc_valid,
    input  logic [AW-1:0]   alloc_rd,
    input  logic            flush,
    output logic [CW-1:0]   pending_cnt,
    output logic            full_zero_hit
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic we_eff;
    logic alloc_eff;
    logic inc;
    logic dec;

    // Register 0 swallows writes and allocations when hardwired.
    assign we_eff    = we & ~(ZERO_REG & (wr_addr == '0));
    assign alloc_eff = alloc_valid & ~(ZERO_REG & (alloc_rd == '0));

    assign full_zero_hit = alloc_valid & ZERO_REG & (alloc_rd == '0);

    // Alloc is applied after the clear so a same-register alloc wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (we_eff)
                busy_d[wr_addr] = 1'b0;
            if (alloc_eff)
                busy_d[alloc_rd] = 1'b1;
        end
        if (ZERO_REG)
            busy_d[0] = 1'b0;
    end

    // Counter tracks popcount(busy) via the actual 0->1 / 1->0 transitions.
    assign inc = alloc_eff & ~busy_q[alloc_rd];
    assign dec = we_eff & busy_q[wr_addr]
               & ~(alloc_eff & (alloc_rd == wr_addr));

    always_comb begin
        cnt_d = cnt_q;
        if (flush)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++)
                rf_q[i] <= '0;
        end else if (we_eff) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    assign pending_cnt = cnt_q;

    always_comb begin
        rs1_data = rf_q[rs1_addr];
        rs1_busy = busy_q[rs1_addr];
        if (ZERO_REG && rs1_addr == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end else if (BYPASS && we && wr_addr == rs1_addr) begin
            rs1_data = wr_data;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_data = rf_q[rs2_addr];
        rs2_busy = busy_q[rs2_addr];
        if (ZERO_REG && rs2_addr == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end else if (BYPASS && we && wr_addr == rs2_addr) begin
            rs2_data = wr_data;
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard.
// Two instances (bypass on / bypass off) share stimulus and a reference model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        flush;

    logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic        b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic [5:0]  b_cnt, n_cnt;
    logic        b_fzh, n_fzh;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_rf [32];
    bit          mdl_busy [32];

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .flush(flush), .pending_cnt(b_cnt), .full_zero_hit(b_fzh)
    );

    regfile_scoreboard #(.BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .flush(flush), .pending_cnt(n_cnt), .full_zero_hit(n_fzh)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a,
                                             input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && wr_addr == a) return wr_data;
        return mdl_rf[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a,
                                             input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && wr_addr == a) return 32'h0;
        return {31'h0, mdl_busy[a]};
    endfunction

    function automatic logic [31:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mdl_busy[i]);
        return n;
    endfunction

    task automatic mdl_tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mdl_rf[i]   = 32'h0;
                mdl_busy[i] = 1'b0;
            end
        end else begin
            if (we && wr_addr != 0) mdl_rf[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) mdl_busy[i] = 1'b0;
            end else begin
                if (we && wr_addr != 0) mdl_busy[wr_addr] = 1'b0;
                if (alloc_valid && alloc_rd != 0) mdl_busy[alloc_rd] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] fz;
        fz = {31'h0, alloc_valid && alloc_rd == 0};
        chk({tag, " b.rs1_data"}, b_rs1_data, exp_data(rs1_addr, 1));
        chk({tag, " b.rs2_data"}, b_rs2_data, exp_data(rs2_addr, 1));
        chk({tag, " b.rs1_busy"}, {31'h0, b_rs1_busy}, exp_busy(rs1_addr, 1));
        chk({tag, " b.rs2_busy"}, {31'h0, b_rs2_busy}, exp_busy(rs2_addr, 1));
        chk({tag, " b.cnt"}, {26'h0, b_cnt}, exp_cnt());
        chk({tag, " b.fzh"}, {31'h0, b_fzh}, fz);
        chk({tag, " n.rs1_data"}, n_rs1_data, exp_data(rs1_addr, 0));
        chk({tag, " n.rs2_data"}, n_rs2_data, exp_data(rs2_addr, 0));
        chk({tag, " n.rs1_busy"}, {31'h0, n_rs1_busy}, exp_busy(rs1_addr, 0));
        chk({tag, " n.rs2_busy"}, {31'h0, n_rs2_busy}, exp_busy(rs2_addr, 0));
        chk({tag, " n.cnt"}, {26'h0, n_cnt}, exp_cnt());
        chk({tag, " n.fzh"}, {31'h0, n_fzh}, fz);
    endtask

    // Inputs are set at the negedge; outputs checked 1 unit later,
    // then the model advances at the posedge.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        mdl_tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit w, input logic [4:0] wa,
                         input logic [31:0] wd, input bit av,
                         input logic [4:0] ar, input bit fl,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input string tag);
        reset = 1'b0;
        we = w; wr_addr = wa; wr_data = wd;
        alloc_valid = av; alloc_rd = ar; flush = fl;
        rs1_addr = r1; rs2_addr = r2;
        step(tag);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2,
                        input string tag);
        drive(0, 0, 0, 0, 0, 0, r1, r2, tag);
    endtask

    initial begin
        reset = 1'b1; we = 0; wr_addr = 0; wr_data = 0;
        alloc_valid = 0; alloc_rd = 0; flush = 0;
        rs1_addr = 0; rs2_addr = 0;
        @(posedge clk);
        mdl_tick();
        @(negedge clk);
        idle(5, 7, "post_reset");

        // reset mid-operation
        drive(0, 0, 0, 1, 5, 0, 5, 6, "alloc5");
        drive(0, 0, 0, 1, 6, 0, 5, 6, "alloc6");
        drive(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 5, "wr7");
        idle(7, 6, "pre_reset");
        reset = 1'b1;
        step("in_reset");
        idle(7, 5, "after_reset");
        idle(6, 0, "after_reset2");

        // bypass on vs off
        drive(1, 3, 32'h12345678, 0, 0, 0, 3, 4, "bypass");
        idle(3, 3, "bypass_next");

        // scoreboard lifecycle
        drive(0, 0, 0, 1, 10, 0, 10, 1, "life_c0");
        idle(10, 1, "life_c1");
        idle(10, 2, "life_c2");
        drive(1, 10, 32'hA5, 0, 0, 0, 10, 1, "life_c3");
        idle(10, 1, "life_c4");

        // simultaneous alloc/write same and different registers
        drive(0, 0, 0, 1, 4, 0, 4, 0, "a4");
        drive(1, 4, 32'h44, 1, 4, 0, 4, 0, "a4w4_busy");
        idle(4, 0, "a4w4_after");
        drive(1, 11, 32'h11, 1, 11, 0, 11, 0, "a11w11_idle");
        idle(11, 0, "a11w11_after");
        drive(0, 0, 0, 1, 9, 0, 9, 8, "a9");
        drive(1, 9, 32'h99, 1, 8, 0, 9, 8, "a8w9");
        idle(9, 8, "a8w9_after");

        // zero register
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, "zero");
        idle(0, 8, "zero_after");

        // flush with everything busy
        for (int r = 1; r < 32; r++)
            drive(0, 0, 0, 1, 5'(r), 0, 5'(r), 2, "fill");
        idle(31, 1, "full");
        drive(1, 3, 32'h77, 1, 2, 1, 2, 3, "flush");
        idle(2, 3, "flush_after");

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wa, r1, r2;
            wa = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                we = 1'b1; wr_addr = wa; wr_data = $urandom;
                alloc_valid = 1'b1; alloc_rd = 5'($urandom_range(0, 31));
                flush = 1'b0; rs1_addr = r1; rs2_addr = r2;
                step("rnd_reset");
            end else begin
                drive($urandom_range(0, 1) == 1, wa, $urandom,
                      $urandom_range(0, 2) != 0,
                      5'($urandom_range(0, 31)),
                      $urandom_range(0, 49) == 0, r1, r2, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
